p405s_dcu_st_steer_q: RTL
=========================

P405S_DCU_ST_STEER_Q -- requirements
Module: p405s_dcu_st_steer_q

Interface
REQ-001 Parameter LANES, 4, byte lanes per beat (4 or 8); lane 0 = data bits [0:7] (most significant byte).
REQ-002 Parameter DEPTH, 4, store-queue entries (power of 2, 2..16).
REQ-003 Port CB  in  1  clock; all state updates on rising edge.
REQ-004 Port RST_N  in  1  reset, synchronous, active-low.
REQ-005 Port in_valid  in  1  store request valid.
REQ-006 Port in_ready  out  1  queue can accept this cycle.
REQ-007 Port in_data  in  8*LANES  store bytes, byte k in lane k.
REQ-008 Port in_par  in  LANES  per-byte parity, bit k pairs with lane k.
REQ-009 Port in_addr  in  log2(LANES)  starting byte offset.
REQ-010 Port in_cnt  in  log2(LANES)+1  byte count, legal 1..LANES.
REQ-011 Port in_rev  in  1  byte-reverse (endian swap) the in_cnt bytes.
REQ-012 Port out_valid / out_ready  out / in  1 each  output beat handshake.
REQ-013 Port out_data  out  8*LANES; out_par  out  LANES; out_be  out  LANES byte enables; out_last  out  1 final beat of a store.
REQ-014 Port err_pulse  out  1  illegal count seen; occupancy  out  log2(DEPTH)+1  entries held.

Function
REQ-015 Transfer on in_valid & in_ready; in_ready = (occupancy < DEPTH), registered; a pop frees its slot for push on the following cycle only (no same-cycle full bypass).
REQ-016 Queue is FIFO; entry stores data, parity, addr, cnt, rev unmodified.
REQ-017 Steering per entry: if rev, byte j of first cnt bytes becomes byte cnt-1-j; then byte k goes to lane (addr+k) mod LANES; parity bit travels with its byte.
REQ-018 If addr+cnt <= LANES: single beat, out_be set for lanes addr..addr+cnt-1, out_last=1.
REQ-019 If addr+cnt > LANES: beat 0 enables lanes addr..LANES-1, out_last=0; beat 1 enables lanes 0..addr+cnt-LANES-1, out_last=1.
REQ-020 Disabled lanes drive data 0x00 and parity 0.
REQ-021 FSM states IDLE, BEAT0, BEAT1: IDLE->BEAT0 when queue non-empty; BEAT0->IDLE/BEAT0(next entry) on out_ready for single-beat or after beat 1; BEAT0->BEAT1 on out_ready when split; BEAT1 pops entry on out_ready.
REQ-022 Latency: push into empty queue at cycle N gives out_valid at N+1; back-to-back single-beat stores sustain one beat per cycle.
REQ-023 out_data/out_par/out_be/out_last stable while out_valid & !out_ready.
REQ-024 in_cnt = 0 or > LANES: entry accepted, err_pulse=1 for one cycle when it reaches head, entry dropped, no beat emitted.
REQ-025 Simultaneous push and pop at non-full: occupancy unchanged.

Reset
REQ-026 RST_N low at a CB edge: queue emptied, FSM IDLE, occupancy 0, out_valid 0, out_data 0, out_par 0, out_be 0, out_last 0, err_pulse 0, in_ready 0 during reset and 1 on first cycle after release.
REQ-027 Reset mid split store (BEAT1 pending) discards the remaining beat; no partial beat after release.

Configuration
REQ-028 Macro DCU_STEER_PARITY_EN defined: parity stored per entry and steered per REQ-017.
REQ-029 Macro undefined: parity storage removed, in_par ignored, out_par constant 0; ports remain.

Verification (LANES=4, DEPTH=4, macro defined)
REQ-030 addr=0 cnt=4 rev=0 data 0x11223344 par 1010 -> one beat 0x11223344, be 1111, par 1010, last 1, at N+1.
REQ-031 addr=1 cnt=2 data 0xAABB0000 -> one beat 0x00AABB00, be 0110, last 1.
REQ-032 addr=3 cnt=2 data 0xAABB0000 par 1100 -> beat 0x000000AA be 0001 par 0001 last 0, then 0xBB000000 be 1000 par 1000 last 1.
REQ-033 addr=0 cnt=4 rev=1 data 0x11223344 -> 0x44332211, be 1111.
REQ-034 out_ready=0, push 4 stores -> in_ready 0, occupancy 4; one pop -> in_ready 1 next cycle; cnt=0 store -> err_pulse one cycle, no beat.
REQ-035 RST_N low while beat 1 of split store held -> next cycle out_valid 0, occupancy 0; no beat after release until new push.

Source files
------------

// File: rtl/p405s_dcu_st_steer_q.sv
// Store queue with byte-lane steering: rotates/reverses stored bytes onto lanes, splitting
// stores that cross the beat boundary. Define DCU_STEER_PARITY_EN to keep per-byte parity.
module p405s_dcu_st_steer_q #(
   parameter int LANES = 4,
   parameter int DEPTH = 4
) (
   input  logic                     CB,
   input  logic                     RST_N,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [8*LANES-1:0]       in_data,
   input  logic [LANES-1:0]         in_par,
   input  logic [$clog2(LANES)-1:0] in_addr,
   input  logic [$clog2(LANES):0]   in_cnt,
   input  logic                     in_rev,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [8*LANES-1:0]       out_data,
   output logic [LANES-1:0]         out_par,
   output logic [LANES-1:0]         out_be,
   output logic                     out_last,
   output logic                     err_pulse,
   output logic [$clog2(DEPTH):0]   occupancy
);
   localparam int DW = 8*LANES;
   localparam int AW = $clog2(LANES);
   localparam int CW = AW + 1;
   localparam int PW = $clog2(DEPTH);
   localparam int OW = PW + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2} state_t;

   typedef struct packed {
      logic [DW-1:0]    data;
      logic [LANES-1:0] par;
      logic [LANES-1:0] be;
      logic             last;
   } beat_t;

   // Lane l of beat b holds sequence byte k = l + b*LANES - addr; reversal maps k to cnt-1-k.
   function automatic beat_t steerBeat(input logic [DW-1:0] d, input logic [LANES-1:0] p,
                                       input logic [AW-1:0] a, input logic [CW-1:0] c,
                                       input logic r, input logic b);
      beat_t o;
      int    pos;
      int    k;
      int    src;
      logic  hit;
      o = '0;
      for (int l = 0; l < LANES; l++) begin
         pos = l + (b ? LANES : 0);
         k   = pos - int'(a);
         hit = (pos >= int'(a)) && (k < int'(c)) && (int'(c) <= LANES);
         src = hit ? (r ? int'(c) - 1 - k : k) : 0;
         o.data[8*(LANES-1-l) +: 8] = hit ? d[8*(LANES-1-src) +: 8] : 8'h00;
         o.par[LANES-1-l]           = hit ? p[LANES-1-src] : 1'b0;
         o.be[LANES-1-l]            = hit;
      end
      o.last = b | ((int'(a) + int'(c)) <= LANES);
      return o;
   endfunction

   logic [DW-1:0]    qData_r [DEPTH];
   logic [AW-1:0]    qAddr_r [DEPTH];
   logic [CW-1:0]    qCnt_r  [DEPTH];
   logic             qRev_r  [DEPTH];
   logic [PW-1:0]    wrPtr_r, rdPtr_r, rdPtrNext_s, candIdx_s;
   logic [OW-1:0]    occ_r, occNext_s;
   logic             inReady_r;
   state_t           state_r;
   logic             outValid_r, errPulse_r;
   beat_t            outBeat_r, beat0_s, beat1_s, newBeat_s;
   logic             push_s, outFree_s, consume_s, candInQ_s, candAvail_s;
   logic             candLegal_s, loadNew_s, dropErr_s, candRev_s;
   logic [DW-1:0]    candData_s;
   logic [AW-1:0]    candAddr_s;
   logic [CW-1:0]    candCnt_s;
   logic [LANES-1:0] candPar_s, headPar_s;

`ifdef DCU_STEER_PARITY_EN
   logic [LANES-1:0] qPar_r [DEPTH];

   // Parity storage, written alongside the rest of the entry
   always_ff @(posedge CB) begin
      if (push_s) begin
         qPar_r[wrPtr_r] <= in_par;
      end
   end
   assign candPar_s = candInQ_s ? qPar_r[candIdx_s] : in_par;
   assign headPar_s = qPar_r[rdPtr_r];
`else
   logic unusedPar_s;
   assign unusedPar_s = ^in_par;
   assign candPar_s   = {LANES{1'b0}};
   assign headPar_s   = {LANES{1'b0}};
`endif

   // Pick the entry that becomes head once the output stage frees; an empty queue takes the push directly
   always_comb begin
      push_s      = in_valid & inReady_r;
      outFree_s   = ~outValid_r | (out_ready & outBeat_r.last);
      consume_s   = outValid_r & out_ready & outBeat_r.last;
      candIdx_s   = rdPtr_r + PW'(outValid_r);
      candInQ_s   = occ_r > OW'(outValid_r);
      candAvail_s = outFree_s & (candInQ_s | push_s);
      if (candInQ_s) begin
         candData_s = qData_r[candIdx_s];
         candAddr_s = qAddr_r[candIdx_s];
         candCnt_s  = qCnt_r[candIdx_s];
         candRev_s  = qRev_r[candIdx_s];
      end else begin
         candData_s = in_data;
         candAddr_s = in_addr;
         candCnt_s  = in_cnt;
         candRev_s  = in_rev;
      end
      candLegal_s = (candCnt_s != {CW{1'b0}}) && (candCnt_s <= CW'(LANES));
      loadNew_s   = candAvail_s & candLegal_s;
      dropErr_s   = candAvail_s & ~candLegal_s;
      occNext_s   = occ_r + OW'(push_s) - OW'(consume_s) - OW'(dropErr_s);
      rdPtrNext_s = rdPtr_r + PW'(consume_s) + PW'(dropErr_s);
      beat0_s     = steerBeat(candData_s, candPar_s, candAddr_s, candCnt_s, candRev_s, 1'b0);
      beat1_s     = steerBeat(qData_r[rdPtr_r], headPar_s, qAddr_r[rdPtr_r], qCnt_r[rdPtr_r],
                              qRev_r[rdPtr_r], 1'b1);
      newBeat_s   = loadNew_s ? beat0_s : '0;
   end

   // Queue entry storage
   always_ff @(posedge CB) begin
      if (push_s) begin
         qData_r[wrPtr_r] <= in_data;
         qAddr_r[wrPtr_r] <= in_addr;
         qCnt_r[wrPtr_r]  <= in_cnt;
         qRev_r[wrPtr_r]  <= in_rev;
      end
   end

   // Pointers, occupancy and registered ready (a freed slot is visible one cycle later)
   always_ff @(posedge CB) begin
      if (!RST_N) begin
         wrPtr_r   <= {PW{1'b0}};
         rdPtr_r   <= {PW{1'b0}};
         occ_r     <= {OW{1'b0}};
         inReady_r <= 1'b0;
      end else begin
         wrPtr_r   <= wrPtr_r + PW'(push_s);
         rdPtr_r   <= rdPtrNext_s;
         occ_r     <= occNext_s;
         inReady_r <= (occNext_s < OW'(DEPTH));
      end
   end

   // Output beat FSM; the head entry stays queued until its last beat is taken
   always_ff @(posedge CB) begin
      if (!RST_N) begin
         state_r    <= IDLE;
         outValid_r <= 1'b0;
         outBeat_r  <= '0;
         errPulse_r <= 1'b0;
      end else begin
         errPulse_r <= dropErr_s;
         case (state_r)
            IDLE: begin
               outValid_r <= loadNew_s;
               outBeat_r  <= newBeat_s;
               state_r    <= loadNew_s ? BEAT0 : IDLE;
            end
            BEAT0: begin
               if (out_ready && !outBeat_r.last) begin
                  outBeat_r <= beat1_s;
                  state_r   <= BEAT1;
               end else if (out_ready) begin
                  outValid_r <= loadNew_s;
                  outBeat_r  <= newBeat_s;
                  state_r    <= loadNew_s ? BEAT0 : IDLE;
               end else begin
                  state_r <= BEAT0;
               end
            end
            BEAT1: begin
               if (out_ready) begin
                  outValid_r <= loadNew_s;
                  outBeat_r  <= newBeat_s;
                  state_r    <= loadNew_s ? BEAT0 : IDLE;
               end else begin
                  state_r <= BEAT1;
               end
            end
            default: begin
               outValid_r <= 1'b0;
               outBeat_r  <= '0;
               state_r    <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = inReady_r;
   assign out_valid = outValid_r;
   assign out_data  = outBeat_r.data;
   assign out_par   = outBeat_r.par;
   assign out_be    = outBeat_r.be;
   assign out_last  = outBeat_r.last;
   assign err_pulse = errPulse_r;
   assign occupancy = occ_r;

endmodule
